// File: rtl/prefetch_fetcher.sv
// Prefetching instruction fetcher: reads IM ahead of decode into a DEPTH-entry {pc, instr} FIFO.
// Define FETCH_ALIGN_CHK_EN to raise a sticky fault on misaligned redirect targets.
module prefetch_fetcher #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_en,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic [1:0]  redir_op,
  input  logic [31:0] redir_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] target,
  input  logic [31:0] redir_reg,
  output logic        fault
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [1:0]  OP_BR = 2'b01;
  localparam logic [1:0]  OP_J  = 2'b10;
  localparam logic [1:0]  OP_JR = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  entry_t             head_q, head_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        last_pc_q, last_pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               inflight_q, inflight_d;
  logic               kill_q, kill_d;
  logic               out_valid_q, out_valid_d;

  logic               redirect;
  logic [31:0]        p4;
  logic [31:0]        tgt_raw;
  logic [31:0]        tgt;
  logic [CNT_W:0]     occ;
  logic               issue;
  logic               push;
  logic               pop;
  logic               fault_st;

  assign redirect = (redir_op != 2'b00);
  assign p4       = redir_pc + 32'd4;

  // Redirect target decode
  always_comb begin
    tgt_raw = p4;
    case (redir_op)
      OP_BR:   tgt_raw = p4 + {{14{imm16[15]}}, imm16, 2'b00};
      OP_J:    tgt_raw = {p4[31:28], target, 2'b00};
      OP_JR:   tgt_raw = redir_reg;
      default: tgt_raw = p4;
    endcase
  end

`ifdef FETCH_ALIGN_CHK_EN
  logic fault_q, fault_d;

  assign tgt      = tgt_raw;
  assign fault_st = fault_q;

  always_comb begin
    fault_d = fault_q;
    if (redirect) fault_d = (tgt_raw[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= fault_d;
  end
`else
  assign tgt      = tgt_raw & ~32'h0000_0003;
  assign fault_st = 1'b0;
`endif

  // Space is reserved for the in-flight read so a push never meets a full FIFO
  assign occ   = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
  assign issue = rst && (occ < (CNT_W+1)'(DEPTH)) && !fault_st && !redirect;
  assign push  = inflight_q && !kill_q && !redirect;
  assign pop   = out_valid_q && out_ready && !redirect;

  always_comb begin
    mem_d       = mem_q;
    fetch_pc_d  = fetch_pc_q;
    last_pc_d   = last_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    inflight_d  = 1'b0;
    kill_d      = 1'b0;
    if (redirect) begin
      fetch_pc_d = tgt;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      kill_d     = inflight_q;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: last_pc_q, instr: im_rdata};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        last_pc_d  = fetch_pc_q;
        inflight_d = 1'b1;
      end
    end
    out_valid_d = (count_d != '0);
    head_d      = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q      <= '0;
      fetch_pc_q  <= RESET_PC;
      last_pc_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      head_q      <= head_d;
      fetch_pc_q  <= fetch_pc_d;
      last_pc_q   <= last_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign im_en     = issue;
  assign im_addr   = fetch_pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = head_q.instr;
  assign out_pc    = head_q.pc;
  assign fault     = fault_st;

endmodule

// File: tb/tb_prefetch_fetcher.sv
// Directed bench for prefetch_fetcher: redirect vector table plus reset, backpressure and fault sequences.
module tb_prefetch_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_en;
  logic [31:0] im_addr;
  logic [31:0] im_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  redir_op = 2'b00;
  logic [31:0] redir_pc = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] target = '0;
  logic [31:0] redir_reg = '0;
  logic        fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] rpc;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] rreg;
    logic [31:0] exp_pc;
  } vec_t;

  prefetch_fetcher dut (
    .clk       (clk),
    .rst       (rst),
    .im_en     (im_en),
    .im_addr   (im_addr),
    .im_rdata  (im_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .redir_op  (redir_op),
    .redir_pc  (redir_pc),
    .imm16     (imm16),
    .target    (target),
    .redir_reg (redir_reg),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word holds its own address, one-cycle read latency
  always @(posedge clk) if (im_en) im_rdata <= im_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_redir(input vec_t v);
    @(negedge clk);
    redir_op = v.op; redir_pc = v.rpc; imm16 = v.imm; target = v.tgt; redir_reg = v.rreg;
    #1 chk({v.name, " im_en in redirect cycle"}, 32'(im_en), 32'd0);
    @(negedge clk);
    redir_op = 2'b00;
    #1 chk({v.name, " im_en R+1"}, 32'(im_en), 32'd1);
    chk({v.name, " im_addr R+1"}, im_addr, v.exp_pc);
    chk({v.name, " out_valid R+1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk({v.name, " out_valid R+2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk({v.name, " out_valid R+3"}, 32'(out_valid), 32'd1);
    chk({v.name, " out_pc R+3"}, out_pc, v.exp_pc);
    chk({v.name, " out_instr R+3"}, out_instr, v.exp_pc);
    @(negedge clk);
    #1 chk({v.name, " out_pc R+4"}, out_pc, v.exp_pc + 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [6];
    vec_t mis;
    int   n;
    vecs[0] = '{"branch back",    2'b01, 32'h0000_3008, 16'hFFFE, 26'h0,       32'h0,         32'h0000_3004};
    vecs[1] = '{"jump",           2'b10, 32'hF000_0010, 16'h0,    26'h0000100, 32'h0,         32'hF000_0400};
    vecs[2] = '{"jr",             2'b11, 32'h0,         16'h0,    26'h0,       32'h0040_0000, 32'h0040_0000};
    vecs[3] = '{"branch fwd",     2'b01, 32'h0000_3000, 16'h0010, 26'h0,       32'h0,         32'h0000_3044};
    vecs[4] = '{"jump region",    2'b10, 32'h1FFF_FFFC, 16'h0,    26'h3FFFFFF, 32'h0,         32'h2FFF_FFFC};
    vecs[5] = '{"jr wrap",        2'b11, 32'h0,         16'h0,    26'h0,       32'hFFFF_FFFC, 32'hFFFF_FFFC};

    // Reset state and first fetch
    #1 rst = 1'b0;
    #1 chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_pc", out_pc, 32'd0);
    chk("reset out_instr", out_instr, 32'd0);
    chk("reset im_en", 32'(im_en), 32'd0);
    chk("reset fault", 32'(fault), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("first im_en", 32'(im_en), 32'd1);
    chk("first im_addr", im_addr, 32'h0000_3000);
    @(negedge clk);
    #1 chk("second im_addr", im_addr, 32'h0000_3004);
    chk("out_valid N+1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk("out_valid N+2", 32'(out_valid), 32'd1);
    chk("first out_pc", out_pc, 32'h0000_3000);
    chk("first out_instr", out_instr, 32'h0000_3000);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1 chk("stream out_valid", 32'(out_valid), 32'd1);
      chk("stream out_pc", out_pc, 32'h0000_3000 + 32'(4 * k));
    end

    for (int i = 0; i < 6; i++) run_redir(vecs[i]);

    // Back-to-back redirects: the second one wins
    @(negedge clk);
    redir_op = 2'b10; redir_pc = 32'hF000_0010; target = 26'h0000100;
    @(negedge clk);
    redir_op = 2'b11; redir_reg = 32'h0040_0000;
    #1 chk("b2b im_en", 32'(im_en), 32'd0);
    chk("b2b out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    redir_op = 2'b00;
    #1 chk("b2b im_addr", im_addr, 32'h0040_0000);
    @(negedge clk);
    #1 chk("b2b out_valid R+2", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk("b2b out_pc", out_pc, 32'h0040_0000);
    chk("b2b out_valid R+3", 32'(out_valid), 32'd1);

    // Misaligned jr target
`ifdef FETCH_ALIGN_CHK_EN
    @(negedge clk);
    redir_op = 2'b11; redir_reg = 32'h0000_3006;
    @(negedge clk);
    redir_op = 2'b00;
    #1 chk("misalign fault", 32'(fault), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("fault blocks im_en", 32'(im_en), 32'd0);
      chk("fault out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1;
    end
    redir_op = 2'b11; redir_reg = 32'h0000_3000;
    @(negedge clk);
    redir_op = 2'b00;
    #1 chk("fault cleared", 32'(fault), 32'd0);
    chk("resume im_en", 32'(im_en), 32'd1);
    chk("resume im_addr", im_addr, 32'h0000_3000);
    repeat (2) @(negedge clk);
    #1 chk("resume out_pc", out_pc, 32'h0000_3000);
`else
    mis = '{"jr misaligned", 2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_3006, 32'h0000_3004};
    run_redir(mis);
    chk("no fault", 32'(fault), 32'd0);
`endif

    // Backpressure: exactly DEPTH issues, then in-order drain
    out_ready = 1'b0;
    do_reset();
    n = 0;
    for (int k = 0; k < 10; k++) begin
      #1 if (im_en) n++;
      @(negedge clk);
    end
    #1 chk("issues under backpressure", 32'(n), 32'd4);
    chk("im_en stalled", 32'(im_en), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("drain out_valid", 32'(out_valid), 32'd1);
      chk("drain out_pc", out_pc, 32'h0000_3000 + 32'(4 * k));
      @(negedge clk);
    end

    // Reset mid-operation with 3 entries buffered and a read in flight
    out_ready = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    #1 chk("pre-reset out_valid", 32'(out_valid), 32'd1);
    chk("pre-reset out_pc", out_pc, 32'h0000_3000);
    rst = 1'b0;
    #1 chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset out_pc", out_pc, 32'd0);
    chk("midreset out_instr", out_instr, 32'd0);
    chk("midreset im_en", 32'(im_en), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    #1 chk("restart im_addr", im_addr, 32'h0000_3000);
    chk("restart im_en", 32'(im_en), 32'd1);
    @(negedge clk);
    #1 chk("restart out_valid N+1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk("restart out_pc", out_pc, 32'h0000_3000);
    chk("restart out_instr", out_instr, 32'h0000_3000);
    @(negedge clk);
    #1 chk("restart next out_pc", out_pc, 32'h0000_3004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
